mac_row_feeder: RTL and testbench

//  West-edge driver for the MAC tile array. Pulls row-wide activation/weight vectors from the L0 buffer and

---
 rtl/mac_row_feeder.sv | 210 +++++++++++++++++++++
 tb/tb_mac_row_feeder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_row_feeder.sv
// -----------------------------------------------------------------------------
// mac_row_feeder
// West-edge driver for the MAC tile array. One start pulse runs a full
// sequence: kernel load (col vectors, inst 01), one idle gap cycle, execute
// (exec_len vectors, inst 10), then a drain so the last lane can finish.
//
// Optional feature macro: ROW_SKEW_EN
//   defined   : lane r is delayed by r extra register stages (data + inst
//               travel together); DRAIN lasts row cycles.
//   undefined : all lanes driven aligned, no skew registers; DRAIN lasts 1.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset
//   start     1-cycle pulse, begins a sequence when idle
//   exec_len  execute vector count, latched on the accepted start
//   in_data   L0 vector, lane r = in_data[r*bw +: bw]
//   in_valid  in_data valid
//   in_ready  feeder accepts in_data this cycle (LOAD/EXEC only)
//   out_w     to in_w of tile (r,0), lane r = out_w[r*bw +: bw]
//   inst_w    to inst_w of tile (r,0); [r*2+1]=execute, [r*2]=kernel load
//   busy      high whenever the sequencer is not idle
//   done      1-cycle pulse in the final DRAIN cycle
//
// States
//   IDLE  | waiting for start
//   LOAD  | accepting col kernel vectors, inst 01
//   GAP   | single idle cycle between load and execute
//   EXEC  | accepting exec_len vectors, inst 10
//   DRAIN | flushing the skew pipes; done on the last cycle
// -----------------------------------------------------------------------------
module mac_row_feeder #(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [len_bw-1:0]   exec_len,
  input  logic [row*bw-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [row*bw-1:0]   out_w,
  output logic [row*2-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

`ifdef ROW_SKEW_EN
  localparam int drain_cycles = row;
`else
  localparam int drain_cycles = 1;
`endif

  localparam logic [len_bw-1:0] load_last  = len_bw'(col - 1);
  localparam logic [len_bw-1:0] drain_last = len_bw'(drain_cycles - 1);
  localparam logic [1:0]        inst_load  = 2'b01;
  localparam logic [1:0]        inst_exec  = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [len_bw-1:0]   cnt_q, cnt_d;
  logic [len_bw-1:0]   len_q, len_d;
  logic [row*bw-1:0]   src_data_q, src_data_d;
  logic [1:0]          src_inst_q, src_inst_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  // One counter serves all three counted phases; it is zeroed on every
  // phase change so each phase starts from 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    src_data_d = src_data_q;
    src_inst_d = 2'b00;
    accept     = in_valid & in_ready_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          len_d   = exec_len;
        end
      end
      LOAD: begin
        if (accept) begin
          src_data_d = in_data;
          src_inst_d = inst_load;
          if (cnt_q == load_last) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + len_bw'(1);
          end
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = (len_q == '0) ? DRAIN : EXEC;
      end
      EXEC: begin
        if (accept) begin
          src_data_d = in_data;
          src_inst_d = inst_exec;
          if (cnt_q == len_q - len_bw'(1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + len_bw'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == drain_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + len_bw'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    in_ready_d = (state_d == LOAD) || (state_d == EXEC);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DRAIN) && (cnt_d == drain_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      src_data_q <= '0;
      src_inst_q <= 2'b00;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      src_data_q <= src_data_d;
      src_inst_q <= src_inst_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef ROW_SKEW_EN
  for (genvar r = 0; r < row; r++) begin : g_lane
    if (r == 0) begin : g_direct
      assign out_w[0 +: bw]  = src_data_q[0 +: bw];
      assign inst_w[0 +: 2]  = src_inst_q;
    end else begin : g_skew
      // Stage 0 is fed from the source register, so lane r lands r cycles
      // after lane 0.
      logic [bw+1:0] pipe_q [r];
      logic [bw+1:0] pipe_d [r];

      always_comb begin
        pipe_d[0] = {src_inst_q, src_data_q[r*bw +: bw]};
        for (int i = 1; i < r; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < r; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign out_w[r*bw +: bw] = pipe_q[r-1][bw-1:0];
      assign inst_w[r*2 +: 2]  = pipe_q[r-1][bw +: 2];
    end
  end
`else
  assign out_w  = src_data_q;
  assign inst_w = {row{src_inst_q}};
`endif

endmodule

// File: tb/tb_mac_row_feeder.sv
module tb_mac_row_feeder;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LBW = 16;
  localparam int DW  = ROW * BW;
  localparam int BUN = 3 + ROW * 2 + DW;
`ifdef ROW_SKEW_EN
  localparam int SK = 1;
  localparam int D  = ROW;
`else
  localparam int SK = 0;
  localparam int D  = 1;
`endif

  logic            clk;
  logic            reset;
  logic            start;
  logic [LBW-1:0]  exec_len;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   out_w;
  logic [ROW*2-1:0] inst_w;
  logic            busy;
  logic            done;

  mac_row_feeder #(.bw(BW), .row(ROW), .col(COL), .len_bw(LBW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .exec_len (exec_len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_w    (out_w),
    .inst_w   (inst_w),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining work per phase, plus a per-cycle history of
  // what the row-0 source stage emitted. Lane r replays that history r*SK
  // cycles later.
  int          vec, miss;
  int          cyc, bound;
  int          load_left, exec_left, drain_left;
  bit          gap_pending;
  logic [DW-1:0] last_data;
  logic [1:0]  ev_inst [0:8191];
  logic [DW-1:0] ev_data [0:8191];
  logic [BUN-1:0] act_b, exp_b;
  bit          last_acc;

  function automatic bit running();
    return (load_left > 0) || gap_pending || (exec_left > 0) || (drain_left > 0);
  endfunction

  function automatic logic [DW-1:0] ramp(input int k);
    logic [DW-1:0] v;
    for (int r = 0; r < ROW; r++) v[r*BW +: BW] = BW'((k + r) % 16);
    return v;
  endfunction

  // Samples this cycle's outputs, forms the expected ones, drives inputs,
  // advances one clock.
  task automatic tick(input logic st, input logic v, input logic [DW-1:0] d,
                      input logic [LBW-1:0] len, input logic rst);
    logic [DW-1:0]    eo;
    logic [ROW*2-1:0] ei;
    logic [1:0]       ins;
    bit e_ready, e_busy, e_done, acc;
    int idx;
    for (int r = 0; r < ROW; r++) begin
      idx = cyc - 1 - r * SK;
      if (idx >= bound && idx >= 0) begin
        eo[r*BW +: BW] = ev_data[idx][r*BW +: BW];
        ei[r*2 +: 2]   = ev_inst[idx];
      end else begin
        eo[r*BW +: BW] = '0;
        ei[r*2 +: 2]   = 2'b00;
      end
    end
    e_ready = (load_left > 0) || (!gap_pending && exec_left > 0);
    e_busy  = running();
    e_done  = (load_left == 0) && !gap_pending && (exec_left == 0) && (drain_left == 1);
    exp_b = {e_ready, e_busy, e_done, ei, eo};
    act_b = {in_ready, busy, done, inst_w, out_w};

    start = st; in_valid = v; in_data = d; exec_len = len; reset = rst;

    ins = 2'b00;
    acc = 1'b0;
    if (rst) begin
      load_left = 0; exec_left = 0; drain_left = 0; gap_pending = 0;
      last_data = '0;
      bound = cyc + 1;
    end else begin
      acc = v && e_ready;
      if (!e_busy) begin
        if (st) begin
          load_left = COL; gap_pending = 1; exec_left = int'(len); drain_left = D;
        end
      end else if (load_left > 0) begin
        if (acc) begin ins = 2'b01; last_data = d; load_left--; end
      end else if (gap_pending) begin
        gap_pending = 0;
      end else if (exec_left > 0) begin
        if (acc) begin ins = 2'b10; last_data = d; exec_left--; end
      end else begin
        drain_left--;
      end
    end
    ev_inst[cyc] = ins;
    ev_data[cyc] = last_data;
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int dones_rst, dones_run, n;
    tick(0, 0, '0, '0, 1);
    tick(0, 0, '0, '0, 1);
    repeat (2) begin
      tick(0, 0, '0, '0, 0);
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    end
    tick(1, 0, '0, 16'd5, 0);
    vec++; if (act_b !== exp_b) begin miss++; $display("FAIL reset_start cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    repeat (12) begin
      tick(0, 1, DW'($urandom), '0, 0);
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL reset_pre cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    end
    dones_rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, DW'($urandom), 16'd7, (i < 3));
      if (act_b[BUN-3] === 1'b1) dones_rst++;
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
      if (i == 1) begin
        vec++; if (act_b !== '0) begin miss++; $display("FAIL reset_clear got=%h want=0", act_b); end
      end
    end
    vec++; if (dones_rst != 0) begin miss++; $display("FAIL reset_no_done got=%0d want=0", dones_rst); end
    tick(1, 0, '0, 16'd2, 0);
    vec++; if (act_b !== exp_b) begin miss++; $display("FAIL reset_restart cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    dones_run = 0; n = 0;
    while ((running() || n < 2) && n < 60) begin
      tick(0, 1, DW'($urandom), '0, 0);
      if (act_b[BUN-3] === 1'b1) dones_run++;
      n++;
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL reset_rerun cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    end
    vec++; if (dones_run != 1) begin miss++; $display("FAIL reset_rerun_done got=%0d want=1", dones_run); end
  endtask

  task automatic test_load();
    int k, n, n01, n10, last_acc_cyc, done_cyc;
    tick(1, 0, '0, 16'd4, 0);
    vec++; if (act_b !== exp_b) begin miss++; $display("FAIL load_start cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    k = 0; n = 0; n01 = 0; n10 = 0; last_acc_cyc = -1; done_cyc = -1;
    while ((running() || n < 2) && n < 60) begin
      tick(0, 1, ramp(k), '0, 0);
      if (last_acc) begin k++; last_acc_cyc = cyc - 1; end
      if (act_b[1:0] == 2'b00 && act_b[DW+1:DW] == 2'b01) n01++;
      if (act_b[DW+1:DW] == 2'b01) ; // counted above only for clarity of lane0 slice
      if (act_b[DW+1:DW] == 2'b10) n10++;
      if (act_b[BUN-3] === 1'b1) done_cyc = cyc - 1;
      n++;
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL load_seq cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    end
    n01 = 0;
    for (int c = cyc - n; c < cyc; c++) if (ev_inst[c] == 2'b01) n01++;
    vec++; if (n01 != COL) begin miss++; $display("FAIL load_count got=%0d want=%0d", n01, COL); end
    vec++; if (n10 != 4) begin miss++; $display("FAIL load_exec_lane0 got=%0d want=4", n10); end
    vec++; if (done_cyc - last_acc_cyc != D) begin miss++; $display("FAIL load_done_delay got=%0d want=%0d", done_cyc - last_acc_cyc, D); end
  endtask

  task automatic test_skew();
    int n, k;
    int first [ROW];
    logic [DW-1:0] d;
    for (int r = 0; r < ROW; r++) first[r] = -1;
    tick(1, 0, '0, 16'd1, 0);
    vec++; if (act_b !== exp_b) begin miss++; $display("FAIL skew_start cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    n = 0; k = 0;
    while ((running() || n < 2) && n < 60) begin
      d = (k < COL) ? DW'($urandom) : {ROW{4'hA}};
      tick(0, 1, d, '0, 0);
      if (last_acc) k++;
      for (int r = 0; r < ROW; r++)
        if (first[r] < 0 && inst_w_of(act_b, r) == 2'b10 && out_of(act_b, r) == 4'hA) first[r] = cyc - 1;
      n++;
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL skew_seq cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    end
    for (int r = 0; r < ROW; r++) begin
      vec++;
      if (first[0] < 0 || first[r] - first[0] != r * SK) begin
        miss++; $display("FAIL skew_lane%0d got=%0d want=%0d", r, first[r] - first[0], r * SK);
      end
    end
  endtask

  function automatic logic [1:0] inst_w_of(input logic [BUN-1:0] b, input int r);
    logic [ROW*2-1:0] iw;
    iw = b[DW +: ROW*2];
    return iw[r*2 +: 2];
  endfunction

  function automatic logic [BW-1:0] out_of(input logic [BUN-1:0] b, input int r);
    logic [DW-1:0] ow;
    ow = b[DW-1:0];
    return ow[r*BW +: BW];
  endfunction

  task automatic test_bubbles();
    int n, k, gap, n01;
    logic v;
    tick(1, 0, '0, 16'd2, 0);
    vec++; if (act_b !== exp_b) begin miss++; $display("FAIL bub_start cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    n = 0; k = 0; gap = 0; n01 = 0;
    while ((running() || n < 2) && n < 60) begin
      v = !(k == 3 && gap < 2);
      if (!v) gap++;
      tick(0, v, DW'($urandom), '0, 0);
      if (last_acc) k++;
      if (inst_w_of(act_b, 0) == 2'b01) n01++;
      n++;
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL bub_seq cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    end
    vec++; if (n01 != COL) begin miss++; $display("FAIL bub_loads got=%0d want=%0d", n01, COL); end
  endtask

  task automatic test_exec_zero();
    int n, dones, ready_late, n10, loads;
    tick(1, 0, '0, 16'd0, 0);
    vec++; if (act_b !== exp_b) begin miss++; $display("FAIL ez_start cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    n = 0; dones = 0; ready_late = 0; n10 = 0; loads = 0;
    while ((running() || n < 2) && n < 60) begin
      tick(0, 1, DW'($urandom), '0, 0);
      if (loads >= COL && act_b[BUN-1] === 1'b1) ready_late++;
      if (last_acc) loads++;
      for (int r = 0; r < ROW; r++) if (inst_w_of(act_b, r) == 2'b10) n10++;
      if (act_b[BUN-3] === 1'b1) dones++;
      n++;
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL ez_seq cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    end
    vec++; if (ready_late != 0) begin miss++; $display("FAIL ez_ready got=%0d want=0", ready_late); end
    vec++; if (n10 != 0) begin miss++; $display("FAIL ez_exec_inst got=%0d want=0", n10); end
    vec++; if (dones != 1) begin miss++; $display("FAIL ez_done got=%0d want=1", dones); end
  endtask

  task automatic test_start_ignored();
    int n, dones, n10, k;
    tick(1, 0, '0, 16'd3, 0);
    vec++; if (act_b !== exp_b) begin miss++; $display("FAIL ign_start cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    n = 0; dones = 0; n10 = 0; k = 0;
    while ((running() || n < 2) && n < 60) begin
      tick((k == COL + 1), 1, DW'($urandom), 16'd99, 0);
      if (last_acc) k++;
      if (inst_w_of(act_b, 0) == 2'b10) n10++;
      if (act_b[BUN-3] === 1'b1) dones++;
      n++;
      vec++; if (act_b !== exp_b) begin miss++; $display("FAIL ign_seq cyc=%0d got=%h want=%h", cyc-1, act_b, exp_b); end
    end
    vec++; if (n10 != 3) begin miss++; $display("FAIL ign_len got=%0d want=3", n10); end
    vec++; if (dones != 1) begin miss++; $display("FAIL ign_done got=%0d want=1", dones); end
  endtask

  task automatic test_random();
    int n;
    for (int s = 0; s < 6; s++) begin
      n = 0;
      while (n < 120 && (n < 3 || running())) begin
        tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7), DW'($urandom),
             LBW'($urandom_range(0, 5)), (s == 3 && n == 15));
        n++;
        vec++; if (act_b !== exp_b) begin miss++; $display("FAIL rand_seq s=%0d cyc=%0d got=%h want=%h", s, cyc-1, act_b, exp_b); end
      end
    end
  endtask

  initial begin
    vec = 0; miss = 0; cyc = 0; bound = 0;
    load_left = 0; exec_left = 0; drain_left = 0; gap_pending = 0;
    last_data = '0; last_acc = 0;
    reset = 1'b1; start = 1'b0; exec_len = '0; in_data = '0; in_valid = 1'b0;
    test_reset();
    test_load();
    test_skew();
    test_bubbles();
    test_exec_zero();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
